riscv_boot_ctrl: RTL and testbench
==================================

# riscv_boot_ctrl

Boot loader controller that sequences the riscv pipeline core from power-up to run. It holds the core in reset and receives a program image as a byte stream over a valid/ready handshake. It assembles the bytes into 32-bit words, writes them into instruction memory from word address 0, verifies a checksum, then releases the core's reset. It sits between a host byte source (UART/debug receiver), the instruction-memory write port and the core's `irst` input.

## Interface
Parameters:
- `MP_IMEM_ADDR_WIDTH`, 10: instruction memory word-address width; max image = 2^MP_IMEM_ADDR_WIDTH words.
- `MP_ENDIANESS`, `` `RISCV_BIG_ENDIAN ``: byte order used for both header and payload words.
- `MP_TIMEOUT`, 1000000: number of consecutive idle cycles inside a started packet that causes an abort.

Ports:
- `iclk` in 1: clock.
- `irst` in 1: reset. Synchronous, active-high.
- `irx_data` in 8: incoming byte.
- `irx_valid` in 1: byte valid.
- `orx_ready` out 1: controller accepts a byte. A byte transfers when `irx_valid && orx_ready`.
- `oimem_wr_en` out 1: instruction memory write strobe.
- `oimem_wr_addr` out MP_IMEM_ADDR_WIDTH: word address.
- `oimem_wr_data` out 32: word data.
- `ocore_rst` out 1: drives the core's `irst`.
- `oboot_done` out 1: image loaded; core running.
- `oboot_err` out 1: load aborted.
- `ireload` in 1: restart the load sequence.

## Operation
- Packet format:
  - 4-byte header N (word count).
  - N×4 payload bytes.
  - 1 checksum byte = XOR of all payload bytes. The header is excluded from the checksum.
- States:
  - HDR: collect 4 header bytes.
  - DATA: collect payload words.
  - CSUM: compare the checksum byte.
  - RUN: core running.
  - ERR: load aborted.
- Byte counter: 2-bit, counts bytes within the current word.
  - Big endian: first byte goes to [31:24].
  - Little endian: first byte goes to [7:0].
- HDR, on the 4th byte:
  - N==0 or N>2^MP_IMEM_ADDR_WIDTH → ERR.
  - Otherwise → DATA, with word index cleared to 0.
  - The N comparison uses all 32 header bits.
  - The word counter is MP_IMEM_ADDR_WIDTH+1 bits wide.
- DATA, on the 4th byte of each word:
  - Register a write: addr = word index, data = assembled word.
  - Increment the word index.
  - After word N-1 → CSUM.
- CSUM, on the checksum byte:
  - Match → RUN.
  - Mismatch → ERR.
  - The running XOR clears on entry to HDR.
- `orx_ready` = 1 in HDR/DATA/CSUM and 0 in RUN/ERR. It is forced to 0 while `irst` is high.
- Timeout: an idle counter counts cycles with no transfer while in HDR/DATA/CSUM with at least one packet byte received.
  - It clears on every transfer.
  - After MP_TIMEOUT consecutive idle cycles → ERR.
  - Idle time in HDR before the first byte never times out.
- `ireload`:
  - From any state → HDR.
  - Clears the byte, word, XOR and timeout counters.
  - A byte transferred in the same cycle is discarded.
  - `ireload` has priority over all other transitions.
- `irst` mid-load:
  - Everything returns to reset values.
  - Words already written stay in memory and are not erased.
  - The next load restarts at address 0.

## Timing
- Reset values:
  - state = HDR.
  - `ocore_rst` = 1, `oboot_done` = 0, `oboot_err` = 0.
  - `oimem_wr_en` = 0, `oimem_wr_addr` = 0, `oimem_wr_data` = 0.
  - `orx_ready` = 0 while `irst` is high, 1 from the first cycle after it.
- `oimem_wr_en` pulses for exactly 1 cycle. It is high in the cycle after the handshake of a word's 4th byte; addr and data are valid with it. Addr and data hold their values between writes.
- Back-to-back bytes are accepted every cycle; there is no internal stall.
- `ocore_rst`, `oboot_done` and `oboot_err` are registered state decodes:
  - `ocore_rst` = !RUN, so it falls the cycle after the checksum handshake.
  - `oboot_done` = RUN.
  - `oboot_err` = ERR.
- The state change caused by the header's 4th byte is visible the next cycle. ERR on a bad N means no write ever occurs.
- Timeout → ERR is entered on the edge that ends the MP_TIMEOUT-th idle cycle.
- `ireload` → HDR is entered the next edge. `ocore_rst` = 1 from that cycle.

## Structure
- The shared defines header holds `` `RISCV_BIG_ENDIAN `` / `` `RISCV_LITTLE_ENDIAN `` and the state encoding localparams (3-bit: HDR, DATA, CSUM, RUN, ERR).
- One sub-module, `riscv_boot_asm`:
  - Byte-to-word assembler: shift register, endianness select, 2-bit byte counter.
  - Signals `oword_valid` on the 4th byte.
  - Has a clear input.
- FSM, counters, XOR and timeout stay in `riscv_boot_ctrl`.

## Test plan
Bench parameters: MP_IMEM_ADDR_WIDTH=4, MP_TIMEOUT=16.
- Big-endian load, bytes 00 00 00 02 | 00 00 00 13 | DE AD BE EF | 31 → writes addr0=0x00000013 and addr1=0xDEADBEEF. `ocore_rst` falls the cycle after byte 0x31; `oboot_done`=1, `orx_ready`=0.
- Little endian, bytes 02 00 00 00 | 13 00 00 00 | EF BE AD DE | 31 → identical writes and RUN.
- Big-endian image from the first scenario with checksum 0x30 → ERR: `oboot_err`=1, `ocore_rst`=1, `orx_ready`=0. Then `ireload` pulse → HDR, `orx_ready`=1; a correct reload reaches RUN.
- Header N=0 and N=17 → ERR after the 4th header byte with no `oimem_wr_en`. Header N=16 with 64 bytes → 16 writes to addr 0..15, then RUN.
- Stop after 2 payload bytes: 15 idle cycles then the remaining bytes → normal completion. 16 idle cycles → ERR.
- `irx_valid` toggling every other cycle → same results as the first scenario. `ireload` mid-DATA with a byte in the same cycle → byte discarded, HDR, next word written at addr 0. Same check with `irst` mid-DATA.

Source files
------------

// File: rtl/riscv_boot_pkg.sv
// Shared definitions for the boot loader: endianness selectors and the 3-bit FSM state encoding.
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif

package riscv_boot_pkg;
  localparam int ENDIAN_BIG    = `RISCV_BIG_ENDIAN;
  localparam int ENDIAN_LITTLE = `RISCV_LITTLE_ENDIAN;

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_CSUM = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    S_HDR  = ST_HDR,
    S_DATA = ST_DATA,
    S_CSUM = ST_CSUM,
    S_RUN  = ST_RUN,
    S_ERR  = ST_ERR
  } boot_state_e;
endpackage

// File: rtl/riscv_boot_asm.sv
// Byte-to-word assembler. oword/oword_valid are combinational on the 4th byte so the
// caller can register the write in the same edge as the handshake.
module riscv_boot_asm #(
  parameter int MP_ENDIANESS = `RISCV_BIG_ENDIAN
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        iclr,
  input  logic [7:0]  ibyte,
  input  logic        ivalid,
  output logic [31:0] oword,
  output logic        oword_valid
);
  logic [1:0]  cnt_q;
  logic [23:0] sr_q, sr_d;

  // Only the first three bytes are stored; the 4th is taken straight from ibyte.
  generate
    if (MP_ENDIANESS == `RISCV_BIG_ENDIAN) begin : g_be
      assign oword = {sr_q, ibyte};
      assign sr_d  = {sr_q[15:0], ibyte};
    end else begin : g_le
      assign oword = {ibyte, sr_q};
      assign sr_d  = {ibyte, sr_q[23:8]};
    end
  endgenerate

  assign oword_valid = ivalid && (cnt_q == 2'd3);

  always_ff @(posedge iclk) begin
    if (irst || iclr) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (ivalid) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/riscv_boot_ctrl.sv
// Boot loader controller: receives header/payload/checksum byte stream, writes words to
// instruction memory from address 0 and releases the core reset on a good checksum.
module riscv_boot_ctrl
  import riscv_boot_pkg::*;
#(
  parameter int MP_IMEM_ADDR_WIDTH = 10,
  parameter int MP_ENDIANESS       = `RISCV_BIG_ENDIAN,
  parameter int MP_TIMEOUT         = 1000000
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [7:0]                    irx_data,
  input  logic                          irx_valid,
  output logic                          orx_ready,
  output logic                          oimem_wr_en,
  output logic [MP_IMEM_ADDR_WIDTH-1:0] oimem_wr_addr,
  output logic [31:0]                   oimem_wr_data,
  output logic                          ocore_rst,
  output logic                          oboot_done,
  output logic                          oboot_err,
  input  logic                          ireload
);
  localparam int          AW        = MP_IMEM_ADDR_WIDTH;
  localparam int          TW        = $clog2(MP_TIMEOUT + 1);
  localparam logic [31:0] MAX_WORDS = 32'(2 ** AW);

  boot_state_e   state_q, state_d;
  logic          in_load, xfer, asm_vld, word_vld, hdr_bad, timeout;
  logic [31:0]   word;
  logic [AW:0]   widx_q, nw_q;
  logic [7:0]    csum_q;
  logic          started_q;
  logic [TW-1:0] idle_q;

  assign in_load   = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign orx_ready = !irst && in_load;
  assign xfer      = irx_valid && orx_ready;
  // A byte arriving alongside ireload is dropped; checksum bytes never enter the assembler.
  assign asm_vld   = xfer && !ireload && ((state_q == S_HDR) || (state_q == S_DATA));
  assign hdr_bad   = (word == 32'd0) || (word > MAX_WORDS);
  assign timeout   = in_load && started_q && !xfer && (idle_q == TW'(MP_TIMEOUT - 1));

  riscv_boot_asm #(.MP_ENDIANESS(MP_ENDIANESS)) u_asm (
    .iclk        (iclk),
    .irst        (irst),
    .iclr        (ireload),
    .ibyte       (irx_data),
    .ivalid      (asm_vld),
    .oword       (word),
    .oword_valid (word_vld)
  );

  always_ff @(posedge iclk) begin
    if (irst) state_q <= S_HDR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ireload) state_d = S_HDR;
    else if (timeout) state_d = S_ERR;
    else begin
      case (state_q)
        S_HDR:  if (word_vld) state_d = hdr_bad ? S_ERR : S_DATA;
        S_DATA: if (word_vld && (widx_q == nw_q - 1'b1)) state_d = S_CSUM;
        S_CSUM: if (xfer) state_d = (irx_data == csum_q) ? S_RUN : S_ERR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (irst || ireload) begin
      widx_q    <= '0;
      nw_q      <= '0;
      csum_q    <= '0;
      started_q <= 1'b0;
      idle_q    <= '0;
    end else begin
      if (xfer) begin
        started_q <= 1'b1;
        idle_q    <= '0;
      end else if (in_load && started_q) begin
        idle_q <= idle_q + 1'b1;
      end
      if (word_vld && state_q == S_HDR) begin
        nw_q   <= word[AW:0];
        widx_q <= '0;
      end
      if (word_vld && state_q == S_DATA) widx_q <= widx_q + 1'b1;
      if (xfer && state_q == S_DATA) csum_q <= csum_q ^ irx_data;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      oimem_wr_en   <= 1'b0;
      oimem_wr_addr <= '0;
      oimem_wr_data <= '0;
    end else begin
      oimem_wr_en <= word_vld && (state_q == S_DATA);
      if (word_vld && state_q == S_DATA) begin
        oimem_wr_addr <= widx_q[AW-1:0];
        oimem_wr_data <= word;
      end
    end
  end

  assign ocore_rst  = (state_q != S_RUN);
  assign oboot_done = (state_q == S_RUN);
  assign oboot_err  = (state_q == S_ERR);
endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Scoreboard bench for riscv_boot_ctrl: one big-endian and one little-endian instance,
// expected memory writes queued as payload is driven and popped on each write strobe.
module tb_riscv_boot_ctrl;
  import riscv_boot_pkg::*;
  localparam int AW = 4;
  localparam int TO = 16;

  logic clk = 1'b0, rst = 1'b1, reload = 1'b0;
  logic [7:0] be_rx = '0, le_rx = '0;
  logic be_valid = 1'b0, le_valid = 1'b0;
  logic be_ready, be_wr_en, be_core_rst, be_done, be_err;
  logic le_ready, le_wr_en, le_core_rst, le_done, le_err;
  logic [AW-1:0] be_addr, le_addr;
  logic [31:0] be_wdata, le_wdata;

  always #5 clk = ~clk;

  riscv_boot_ctrl #(.MP_IMEM_ADDR_WIDTH(AW), .MP_ENDIANESS(ENDIAN_BIG), .MP_TIMEOUT(TO)) u_be (
    .iclk(clk), .irst(rst), .irx_data(be_rx), .irx_valid(be_valid), .orx_ready(be_ready),
    .oimem_wr_en(be_wr_en), .oimem_wr_addr(be_addr), .oimem_wr_data(be_wdata),
    .ocore_rst(be_core_rst), .oboot_done(be_done), .oboot_err(be_err), .ireload(reload));

  riscv_boot_ctrl #(.MP_IMEM_ADDR_WIDTH(AW), .MP_ENDIANESS(ENDIAN_LITTLE), .MP_TIMEOUT(TO)) u_le (
    .iclk(clk), .irst(rst), .irx_data(le_rx), .irx_valid(le_valid), .orx_ready(le_ready),
    .oimem_wr_en(le_wr_en), .oimem_wr_addr(le_addr), .oimem_wr_data(le_wdata),
    .ocore_rst(le_core_rst), .oboot_done(le_done), .oboot_err(le_err), .ireload(reload));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int n_cmp = 0, n_err = 0;
  wr_t exp_q[$];
  bit sel_le = 1'b0;
  logic [31:0] img [16];

  wire s_ready    = sel_le ? le_ready    : be_ready;
  wire s_core_rst = sel_le ? le_core_rst : be_core_rst;
  wire s_done     = sel_le ? le_done     : be_done;
  wire s_err      = sel_le ? le_err      : be_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (be_wr_en === 1'b1 || le_wr_en === 1'b1) begin
      wr_t got, e;
      got = (be_wr_en === 1'b1) ? {be_addr, be_wdata} : {le_addr, le_wdata};
      if (exp_q.size() == 0) chk("wr_pending", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(got.addr), 32'(e.addr));
        chk("wr_data", got.data, e.data);
      end
    end
  end

  function automatic logic [7:0] wb(input logic [31:0] w, input int k);
    return sel_le ? w[8*k +: 8] : w[31-8*k -: 8];
  endfunction

  task automatic put(input logic [7:0] b);
    if (sel_le) begin le_valid = 1'b1; le_rx = b; end
    else        begin be_valid = 1'b1; be_rx = b; end
    @(posedge clk); #1;
    be_valid = 1'b0; le_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit alt);
    for (int k = 0; k < 4; k++) begin
      if (alt) idle(1);
      put(wb(w, k));
    end
  endtask

  // Header, nw payload words from img, checksum XOR cx; optional pause after payload byte p.
  task automatic load(input logic [31:0] hdr, input int nw, input logic [7:0] cx, input bit alt,
                      input int p, input int plen);
    logic [7:0] x;
    int bc;
    wr_t e;
    x = '0; bc = 0;
    send_word(hdr, alt);
    for (int i = 0; i < nw; i++) begin
      e.addr = AW'(i); e.data = img[i];
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        if (alt) idle(1);
        put(wb(img[i], k));
        x ^= wb(img[i], k);
        bc++;
        if (bc == p) idle(plen);
      end
    end
    if (alt) idle(1);
    chk("core_rst_pre", s_core_rst, 1'b1);
    put(x ^ cx);
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_core_rst"}, s_core_rst, 1'b0);
    chk({tag, "_done"}, s_done, 1'b1);
    chk({tag, "_err"}, s_err, 1'b0);
    chk({tag, "_ready"}, s_ready, 1'b0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_err(input string tag);
    chk({tag, "_err"}, s_err, 1'b1);
    chk({tag, "_core_rst"}, s_core_rst, 1'b1);
    chk({tag, "_done"}, s_done, 1'b0);
    chk({tag, "_ready"}, s_ready, 1'b0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    chk("reload_ready", s_ready, 1'b1);
    chk("reload_core_rst", s_core_rst, 1'b1);
    chk("reload_err", s_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_be", be_ready, 1'b0);
    chk("rst_ready_le", le_ready, 1'b0);
    chk("rst_core_rst", be_core_rst, 1'b1);
    chk("rst_done", be_done, 1'b0);
    chk("rst_err", be_err, 1'b0);
    chk("rst_wr_en", be_wr_en, 1'b0);
    chk("rst_wr_addr", 32'(be_addr), 32'd0);
    chk("rst_wr_data", be_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", be_ready, 1'b1);

    // big-endian nominal load
    sel_le = 1'b0;
    img[0] = 32'h0000_0013; img[1] = 32'hDEAD_BEEF;
    load(32'd2, 2, 8'h00, 1'b0, -1, 0);
    check_run("be");

    // little-endian nominal load
    sel_le = 1'b1;
    load(32'd2, 2, 8'h00, 1'b0, -1, 0);
    check_run("le");

    // bad checksum (0x30), then recovery
    sel_le = 1'b0;
    do_reload();
    load(32'd2, 2, 8'h01, 1'b0, -1, 0);
    check_err("bad_csum");
    chk("bad_csum_q", 32'(exp_q.size()), 32'd0);
    do_reload();
    load(32'd2, 2, 8'h00, 1'b0, -1, 0);
    check_run("reload_ok");

    // header limits
    do_reload();
    send_word(32'd0, 1'b0);
    check_err("n0");
    do_reload();
    send_word(32'd17, 1'b0);
    check_err("n17");
    idle(2);
    do_reload();
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    load(32'd16, 16, 8'h00, 1'b0, -1, 0);
    check_run("n16");

    // timeout boundary: 15 idle cycles tolerated, 16 abort
    img[0] = 32'h0000_0013; img[1] = 32'hDEAD_BEEF;
    do_reload();
    load(32'd2, 2, 8'h00, 1'b0, 2, 15);
    check_run("idle15");
    do_reload();
    send_word(32'd2, 1'b0);
    put(wb(img[0], 0));
    put(wb(img[0], 1));
    idle(15);
    chk("idle15_no_err", s_err, 1'b0);
    idle(1);
    check_err("idle16");

    // valid toggling every other cycle
    do_reload();
    load(32'd2, 2, 8'h00, 1'b1, -1, 0);
    check_run("toggle");

    // reload mid-DATA with a byte in the same cycle
    do_reload();
    send_word(32'd2, 1'b0);
    put(wb(img[0], 0));
    be_valid = 1'b1; be_rx = 8'hAA; reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0; be_valid = 1'b0;
    chk("mid_reload_ready", s_ready, 1'b1);
    img[0] = 32'hCAFE_F00D;
    load(32'd1, 1, 8'h00, 1'b0, -1, 0);
    check_run("mid_reload");

    // irst mid-DATA after one word already written
    do_reload();
    img[0] = 32'h0BAD_F00D;
    begin
      wr_t e;
      e.addr = '0; e.data = img[0];
      exp_q.push_back(e);
    end
    send_word(32'd2, 1'b0);
    send_word(img[0], 1'b0);
    put(8'h11);
    be_valid = 1'b1; be_rx = 8'h22; rst = 1'b1;
    #1;
    chk("mid_rst_ready", be_ready, 1'b0);
    @(posedge clk); #1;
    be_valid = 1'b0;
    chk("mid_rst_wr_addr", 32'(be_addr), 32'd0);
    chk("mid_rst_wr_data", be_wdata, 32'd0);
    chk("mid_rst_core_rst", be_core_rst, 1'b1);
    rst = 1'b0;
    img[0] = 32'h1234_5678;
    load(32'd1, 1, 8'h00, 1'b0, -1, 0);
    check_run("mid_rst");

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
